// File: rtl/bcd_pkg.sv
// Shared constants for the BCD counter/display slice: nibble width, top BCD digit
// value and the active-high 7-segment patterns (bit 6 = a ... bit 0 = g).
package bcd_pkg;

    localparam int         NIBBLE_W = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD nibble to 7-segment decoder; non-BCD codes render blank.
module bcd_seg_decode
    import bcd_pkg::*;
(
    input  logic [NIBBLE_W-1:0] bcd_i,
    output logic [6:0]          seg_o
);

    // NOTE: the default arm gives seg_o a value on every path, so no latch is inferred.
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter with a time-multiplexed 7-segment scan driver.
// Define BCD_COUNTER_DISPLAY_BLANK_EN to blank leading zeros on digits above 0.
module bcd_counter_display
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       load,
    input  logic [NIBBLE_W*DIGITS-1:0] load_val,
    input  logic                       en,
    input  logic                       up,
    output logic [NIBBLE_W*DIGITS-1:0] count,
    output logic                       carry,
    output logic [6:0]                 seg,
    output logic [DIGITS-1:0]          dig_sel
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [NIBBLE_W*DIGITS-1:0] count_q, count_d;
    logic                       carry_q, carry_d;
    logic [PW-1:0]              presc_q, presc_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [6:0]                 seg_q, seg_d;
    logic [DIGITS-1:0]          dig_sel_q, dig_sel_d;

    logic [NIBBLE_W-1:0]        mux_digit;
    logic [6:0]                 dec_seg;
    logic                       blank;

    // Counter next state: clear beats load beats count; the ripple flag carries
    // the +1/-1 from digit to digit and survives past the top digit only on a wrap.
    always_comb begin
        logic                ripple;
        logic [NIBBLE_W-1:0] nib;
        count_d = count_q;
        carry_d = 1'b0;
        ripple  = 1'b1;
        nib     = '0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                nib = load_val[i*NIBBLE_W +: NIBBLE_W];
                count_d[i*NIBBLE_W +: NIBBLE_W] = (nib > BCD_MAX) ? '0 : nib;
            end
        end else if (en) begin
            for (int i = 0; i < DIGITS; i++) begin
                nib = count_q[i*NIBBLE_W +: NIBBLE_W];
                if (ripple) begin
                    if (up) begin
                        if (nib == BCD_MAX) begin
                            count_d[i*NIBBLE_W +: NIBBLE_W] = '0;
                        end else begin
                            count_d[i*NIBBLE_W +: NIBBLE_W] = nib + 4'd1;
                            ripple = 1'b0;
                        end
                    end else begin
                        if (nib == '0) begin
                            count_d[i*NIBBLE_W +: NIBBLE_W] = BCD_MAX;
                        end else begin
                            count_d[i*NIBBLE_W +: NIBBLE_W] = nib - 4'd1;
                            ripple = 1'b0;
                        end
                    end
                end
            end
            carry_d = ripple;
        end
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    assign mux_digit = count_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];

    bcd_seg_decode u_seg_decode (
        .bcd_i (mux_digit),
        .seg_o (dec_seg)
    );

`ifdef BCD_COUNTER_DISPLAY_BLANK_EN
    // upper_zero[i] is set when digits i..DIGITS-1 are all zero.
    logic [DIGITS:0] upper_zero;
    always_comb begin
        upper_zero[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (count_q[i*NIBBLE_W +: NIBBLE_W] == '0);
        end
    end
    assign blank = (idx_q != '0) && upper_zero[idx_q];
`else
    assign blank = 1'b0;
`endif

    assign seg_d     = blank ? SEG_BLANK : dec_seg;
    assign dig_sel_d = DIGITS'(1) << idx_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which is what makes seg/dig_sel lag by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            carry_q   <= 1'b0;
            presc_q   <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_BLANK;
            dig_sel_q <= '0;
        end else begin
            count_q   <= count_d;
            carry_q   <= carry_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign count   = count_q;
    assign carry   = carry_q;
    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Self-checking bench for bcd_counter_display: directed scenarios plus random
// control traffic against an integer-valued counter and scan-time model.
module tb_bcd_counter_display;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int MODULUS  = 10000;

    logic                clk = 1'b0;
    logic                rst, clr, load, en, up;
    logic [4*DIGITS-1:0] load_val;
    logic [4*DIGITS-1:0] count;
    logic                carry;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   dig_sel;

    int checks   = 0;
    int failures = 0;

    // Model state: count as a plain decimal integer, edges elapsed since reset.
    int                m_val;
    int                m_edges;
    logic              exp_carry;
    logic [6:0]        exp_seg;
    logic [DIGITS-1:0] exp_sel;

    logic [6:0] seg_table [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                   7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                   7'b1111111, 7'b1111011};

    bcd_counter_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up       (up),
        .count    (count),
        .carry    (carry),
        .seg      (seg),
        .dig_sel  (dig_sel)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int from_load(input logic [4*DIGITS-1:0] lv);
        int r = 0;
        for (int i = 0; i < DIGITS; i++) begin
            int n = int'(lv[i*4 +: 4]);
            if (n > 9) n = 0;
            r += n * pow10(i);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_val     = 0;
        m_edges   = 0;
        exp_carry = 1'b0;
        exp_seg   = 7'b0;
        exp_sel   = '0;
    endtask

    // Predict the effect of the coming rising edge from current inputs.
    task automatic model_edge();
        int  idx   = (m_edges / SCAN_DIV) % DIGITS;
        int  digit = (m_val / pow10(idx)) % 10;
        logic blank_digit = 1'b0;
`ifdef BCD_COUNTER_DISPLAY_BLANK_EN
        blank_digit = (idx > 0) && ((m_val / pow10(idx)) == 0);
`endif
        exp_sel = DIGITS'(1) << idx;
        exp_seg = blank_digit ? 7'b0 : seg_table[digit];
        exp_carry = 1'b0;
        if (clr) begin
            m_val = 0;
        end else if (load) begin
            m_val = from_load(load_val);
        end else if (en) begin
            if (up) begin
                exp_carry = (m_val == MODULUS - 1);
                m_val = (m_val + 1) % MODULUS;
            end else begin
                exp_carry = (m_val == 0);
                m_val = (m_val + MODULUS - 1) % MODULUS;
            end
        end
        m_edges++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 0; load = 0; en = 0; up = 0;
    endtask

    task automatic do_load(input logic [4*DIGITS-1:0] v);
        idle();
        load = 1; load_val = v;
        step();
        load = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle(); load_val = '0;
        #12;
        rst = 0;
        model_reset();
        checks++;
        if (count !== '0 || carry !== 1'b0 || seg !== 7'b0 || dig_sel !== '0) begin
            failures++;
            $display("FAIL reset_initial: count=%h carry=%b seg=%b sel=%b, want all zero",
                     count, carry, seg, dig_sel);
        end
        do_load(16'h0123);
        en = 1; up = 1;
        step();
        en = 0;
        #3 rst = 1;
        #1;
        checks++;
        if (count !== '0 || carry !== 1'b0 || seg !== 7'b0 || dig_sel !== '0) begin
            failures++;
            $display("FAIL reset_async: count=%h carry=%b seg=%b sel=%b, want all zero",
                     count, carry, seg, dig_sel);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
        step();
        checks++;
        if (dig_sel !== 4'b0001 || seg !== 7'b1111110 || count !== '0) begin
            failures++;
            $display("FAIL reset_first_edge: sel=%b seg=%b count=%h, want 0001 1111110 0000",
                     dig_sel, seg, count);
        end
    endtask

    task automatic test_up_wrap();
        do_load(16'h9998);
        en = 1; up = 1;
        step();
        checks++;
        if (count !== 16'h9999 || carry !== 1'b0) begin
            failures++;
            $display("FAIL up_9999: count=%h carry=%b, want 9999 0", count, carry);
        end
        step();
        checks++;
        if (count !== 16'h0000 || carry !== 1'b1) begin
            failures++;
            $display("FAIL up_wrap: count=%h carry=%b, want 0000 1", count, carry);
        end
        step();
        checks++;
        if (count !== 16'h0001 || carry !== 1'b0) begin
            failures++;
            $display("FAIL up_carry_pulse: count=%h carry=%b, want 0001 0", count, carry);
        end
    endtask

    task automatic test_down_borrow();
        do_load(16'h1000);
        en = 1; up = 0;
        step();
        checks++;
        if (count !== 16'h0999 || carry !== 1'b0) begin
            failures++;
            $display("FAIL down_borrow: count=%h carry=%b, want 0999 0", count, carry);
        end
        do_load(16'h0000);
        en = 1; up = 0;
        step();
        checks++;
        if (count !== 16'h9999 || carry !== 1'b1) begin
            failures++;
            $display("FAIL down_wrap: count=%h carry=%b, want 9999 1", count, carry);
        end
        idle();
        step();
        checks++;
        if (count !== 16'h9999 || carry !== 1'b0) begin
            failures++;
            $display("FAIL down_hold: count=%h carry=%b, want 9999 0", count, carry);
        end
    endtask

    task automatic test_priority();
        do_load(16'h1234);
        clr = 1; load = 1; en = 1; up = 1; load_val = 16'h5678;
        step();
        checks++;
        if (count !== 16'h0000 || carry !== 1'b0) begin
            failures++;
            $display("FAIL clr_priority: count=%h carry=%b, want 0000 0", count, carry);
        end
        clr = 0; load = 1; en = 1; up = 0; load_val = 16'h2468;
        step();
        checks++;
        if (count !== 16'h2468) begin
            failures++;
            $display("FAIL load_over_en: count=%h, want 2468", count);
        end
        do_load(16'h3A7F);
        checks++;
        if (count !== 16'h3070 || carry !== 1'b0) begin
            failures++;
            $display("FAIL load_invalid: count=%h carry=%b, want 3070 0", count, carry);
        end
    endtask

    task automatic test_scan(input logic [4*DIGITS-1:0] v, input string tag);
        do_load(v);
        idle();
        for (int c = 0; c < 4 * SCAN_DIV * DIGITS; c++) begin
            step();
            checks++;
            if (dig_sel !== exp_sel || seg !== exp_seg) begin
                failures++;
                $display("FAIL %s cycle %0d: sel=%b seg=%b, want %b %b",
                         tag, c, dig_sel, seg, exp_sel, exp_seg);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int r = $urandom_range(0, 31);
            clr  = (r == 0);
            load = (r >= 1 && r <= 4);
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       load_val = 16'h9999;
                1:       load_val = 16'h0000;
                default: load_val = 16'($urandom);
            endcase
            step();
            checks++;
            if (count !== to_bcd(m_val) || carry !== exp_carry ||
                seg !== exp_seg || dig_sel !== exp_sel) begin
                failures++;
                $display("FAIL random cycle %0d: count=%h carry=%b seg=%b sel=%b, want %h %b %b %b",
                         c, count, carry, seg, dig_sel, to_bcd(m_val), exp_carry, exp_seg, exp_sel);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_borrow();
        test_priority();
        test_scan(16'h4321, "scan_4321");
        test_scan(16'h0050, "blank_0050");
        test_scan(16'h0000, "blank_0000");
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
